timer_digit_formatter: RTL and testbench

//  Sits directly downstream of the game countdown timer and consumes its 8-bit seconds value.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_blink_gen.sv | 35 +++
 rtl/timer_digit_formatter.sv | 125 ++++++++++++
 tb/tb_timer_digit_formatter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the on-screen timer digit path.
//   bcd_digit_t    : one BCD nibble
//   fmt_state_t    : digit formatter FSM states
//   DD_STEPS       : double-dabble iterations for an 8-bit binary input
//   BCD_ADD_THRESH : nibble value at or above which +3 is applied before a shift
package timer_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fmt_state_t;

    localparam int DD_STEPS       = 8;
    localparam int BCD_ADD_THRESH = 5;

    // One double-dabble correction: a nibble of 5 or more would pass 9
    // after the shift, so add 3 to make it carry into the next digit.
    function automatic bcd_digit_t dd_adjust(input bcd_digit_t nib);
        if (nib >= 4'(BCD_ADD_THRESH))
            return nib + 4'd3;
        else
            return nib;
    endfunction

endpackage

// File: rtl/timer_blink_gen.sv
// Blink generator for the timer digits.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   enable : level; blinking runs while high
//   blank  : toggles every HALF_PERIOD cycles while enable is high, starting at 0
// While enable is low the counter is held cleared and blank is 0.
module timer_blink_gen #(
    parameter int HALF_PERIOD = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic blank
);

    localparam int CW = $clog2(HALF_PERIOD + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            blank <= 1'b0;
        end else if (!enable) begin
            cnt   <= '0;
            blank <= 1'b0;
        end else if (cnt == CW'(HALF_PERIOD - 1)) begin
            cnt   <= '0;
            blank <= ~blank;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_digit_formatter.sv
// Converts the countdown timer's 8-bit seconds value into three BCD digits
// using a sequential double-dabble engine, and drives a blink flag for the
// renderer once time has elapsed.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   seconds_in   : seconds remaining, 0..255
//   time_elapsed : level, high once the countdown has expired
//   digit_hund   : BCD hundreds digit (0..2)
//   digit_tens   : BCD tens digit
//   digit_ones   : BCD ones digit
//   digits_upd   : one-cycle strobe in the cycle new digits first appear
//   digit_blank  : renderer hides the digits while high
//   busy         : conversion in progress
// Build option: TIMER_DIGIT_BLINK_EN enables the blink generator; without it
// digit_blank is tied low and time_elapsed is ignored.
//
// state | meaning
// IDLE  | waiting for seconds_in to differ from the last converted value
// SHIFT | one double-dabble adjust+shift per cycle, 8 cycles
// DONE  | commit digits, record converted value, pulse digits_upd
module timer_digit_formatter
    import timer_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seconds_in,
    input  logic       time_elapsed,
    output logic [3:0] digit_hund,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_ones,
    output logic       digits_upd,
    output logic       digit_blank,
    output logic       busy
);

    fmt_state_t state, state_nxt;

    logic [7:0]  src;
    logic [7:0]  last_val;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  step;
    logic        changed;

    assign changed = (seconds_in != last_val);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (changed) state_nxt = SHIFT;
            SHIFT:   if (step == 3'(DD_STEPS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src        <= '0;
            last_val   <= '0;
            bin        <= '0;
            bcd        <= '0;
            step       <= '0;
            digit_hund <= '0;
            digit_tens <= '0;
            digit_ones <= '0;
            digits_upd <= 1'b0;
        end else begin
            digits_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (changed) begin
                        // The binary half of the scratch carries the latched value;
                        // the BCD half starts empty.
                        src  <= seconds_in;
                        bin  <= seconds_in;
                        bcd  <= '0;
                        step <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {dd_adjust(bcd[11:8]),
                                   dd_adjust(bcd[7:4]),
                                   dd_adjust(bcd[3:0]),
                                   bin} << 1;
                    step <= step + 3'd1;
                end
                DONE: begin
                    digit_hund <= bcd[11:8];
                    digit_tens <= bcd[7:4];
                    digit_ones <= bcd[3:0];
                    last_val   <= src;
                    digits_upd <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TIMER_DIGIT_BLINK_EN
    timer_blink_gen #(
        .HALF_PERIOD (BLINK_HALF_PERIOD)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .enable (time_elapsed),
        .blank  (digit_blank)
    );
`else
    logic unused_blink;
    assign unused_blink = time_elapsed ^ (BLINK_HALF_PERIOD == 0);
    assign digit_blank  = 1'b0;
`endif

endmodule

// File: tb/tb_timer_digit_formatter.sv
module tb_timer_digit_formatter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seconds_in;
    logic       time_elapsed;
    logic [3:0] digit_hund, digit_tens, digit_ones;
    logic       digits_upd, digit_blank, busy;

    int checks     = 0;
    int failures   = 0;
    int strobe_cnt = 0;

    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    timer_digit_formatter #(
        .BLINK_HALF_PERIOD (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seconds_in   (seconds_in),
        .time_elapsed (time_elapsed),
        .digit_hund   (digit_hund),
        .digit_tens   (digit_tens),
        .digit_ones   (digit_ones),
        .digits_upd   (digits_upd),
        .digit_blank  (digit_blank),
        .busy         (busy)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Scoreboard: every strobe pops the oldest expected digit triple.
    always @(negedge clk) begin
        if (rst === 1'b1 && digits_upd === 1'b1) begin
            logic [11:0] got, want;
            strobe_cnt++;
            checks++;
            got = {digit_hund, digit_tens, digit_ones};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe got=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL digits got=%h required=%h", got, want);
                end
            end
        end
    end

    task automatic wait_strobes(input int target, input int budget, input string name);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (strobe_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout strobes=%0d required=%0d", name, strobe_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        seconds_in = 8'd0;
        time_elapsed = 1'b0;
        #12;
        checks++;
        if ({digit_hund, digit_tens, digit_ones, digits_upd, digit_blank, busy} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {digit_hund, digit_tens, digit_ones, digits_upd, digit_blank, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (strobe_cnt !== 0 || busy !== 1'b0 || {digit_hund, digit_tens, digit_ones} !== 12'd0) begin
            failures++;
            $display("FAIL zero_no_update strobes=%0d busy=%b digits=%h required 0/0/000",
                     strobe_cnt, busy, {digit_hund, digit_tens, digit_ones});
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        seconds_in = 8'd150;
        exp_q.push_back(to_bcd(150));
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (digits_upd !== (k == 10) || busy !== (k <= 9)) begin
                failures++;
                $display("FAIL latency_edge%0d upd=%b busy=%b required upd=%b busy=%b",
                         k, digits_upd, busy, (k == 10), (k <= 9));
            end
        end
        @(negedge clk);
        checks++;
        if (strobe_cnt !== 1) begin
            failures++;
            $display("FAIL latency_strobes got=%0d required=1", strobe_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int base = strobe_cnt;
        @(negedge clk);
        seconds_in = 8'd255;
        exp_q.push_back(to_bcd(255));
        wait_strobes(base + 1, 30, "b2b_255");
        seconds_in = 8'd9;
        exp_q.push_back(to_bcd(9));
        wait_strobes(base + 2, 30, "b2b_9");
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_idle got=%b required=0", busy);
        end
    endtask

    task automatic test_midchange();
        int base = strobe_cnt;
        @(negedge clk);
        seconds_in = 8'd100;
        exp_q.push_back(to_bcd(100));
        exp_q.push_back(to_bcd(99));
        repeat (5) @(posedge clk);   // load edge + 4 shift edges
        @(negedge clk);
        seconds_in = 8'd99;
        wait_strobes(base + 2, 40, "midchange");
        repeat (15) @(negedge clk);
        checks++;
        if (strobe_cnt - base !== 2) begin
            failures++;
            $display("FAIL midchange_strobes got=%0d required=2", strobe_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        @(negedge clk);
        seconds_in = 8'd77;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({digit_hund, digit_tens, digit_ones, digits_upd, busy} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h required=0",
                     {digit_hund, digit_tens, digit_ones, digits_upd, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        base = strobe_cnt;
        exp_q.push_back(to_bcd(77));
        wait_strobes(base + 1, 30, "reset_mid_reconvert");
    endtask

    task automatic test_blink();
        @(negedge clk);
        time_elapsed = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            checks++;
`ifdef TIMER_DIGIT_BLINK_EN
            if (digit_blank !== (((k / 4) % 2) == 1)) begin
                failures++;
                $display("FAIL blink_edge%0d got=%b required=%b", k, digit_blank, ((k / 4) % 2) == 1);
            end
`else
            if (digit_blank !== 1'b0) begin
                failures++;
                $display("FAIL blink_off_edge%0d got=%b required=0", k, digit_blank);
            end
`endif
        end
        @(negedge clk);
        time_elapsed = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (digit_blank !== 1'b0) begin
            failures++;
            $display("FAIL blink_clear got=%b required=0", digit_blank);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_midchange();
        test_reset_mid();
        test_blink();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expected got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
